// File: rtl/uart_frame_seq_if.sv
// Handshake bundle between a message requester and the UART frame sequencer.
// master = requester (drives start), slave = sequencer (drives sel/status).
interface uart_frame_seq_if;
  logic       start;
  logic [5:0] sel;
  logic       busy;
  logic       bit_tick;
  logic       done;

  modport master (output start, input sel, busy, bit_tick, done);
  modport slave  (input start, output sel, busy, bit_tick, done);
endinterface

// File: rtl/uart_frame_seq.sv
// Baud-rate sequencer stepping the UART mux select through NBITS bit indices; outputs registered, sel=0 one cycle after start.
// start is ignored while sending (no queueing); `UART_FRAME_SEQ_REPEAT_EN adds automatic repeats after a GAP_BITS idle gap.
module uart_frame_seq #(
  parameter int CLK_HZ   = 50000000,
  parameter int BAUD     = 9600,
  parameter int DIV      = CLK_HZ / BAUD,
  parameter int NBITS    = 40,
  parameter int IDLE_SEL = 63,
  parameter int GAP_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  uart_frame_seq_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [5:0]  SEL_LAST = 6'(NBITS - 1);
  localparam logic [5:0]  SEL_IDLE = 6'(IDLE_SEL);
  localparam bit CFG_OK = (DIV >= 2) && (DIV <= 65535) && (NBITS >= 1) &&
                          (IDLE_SEL >= NBITS) && (IDLE_SEL <= 63) && (GAP_BITS >= 1);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("uart_frame_seq: illegal parameter combination");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [5:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        tick_q, tick_d;
  logic        done_q, done_d;
  logic [15:0] cnt_q, cnt_d;
  logic        go;

`ifdef UART_FRAME_SEQ_REPEAT_EN
  localparam logic [15:0] GAP_LAST = 16'(GAP_BITS * DIV - 1);
  logic [15:0] gap_q, gap_d;
  logic        rep_q, rep_d;
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
`ifdef UART_FRAME_SEQ_REPEAT_EN
    rep_d   = rep_q;
    gap_d   = gap_q;
    go      = bus.start || (rep_q && (gap_q == GAP_LAST));
`else
    go      = bus.start;
`endif

    if (state_q == IDLE) begin
      if (go) begin
        state_d = SEND;
        sel_d   = 6'd0;
        busy_d  = 1'b1;
        cnt_d   = 16'd0;
      end
    end else begin
      if (cnt_q == DIV_LAST) begin
        cnt_d = 16'd0;
        if (sel_q == SEL_LAST) begin
          state_d = IDLE;
          sel_d   = SEL_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          sel_d = sel_q + 6'd1;
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end

`ifdef UART_FRAME_SEQ_REPEAT_EN
    // Gap counts idle cycles starting with the done cycle; armed only by a completed message.
    if (done_d) rep_d = 1'b1;
    if (state_q == SEND || go) gap_d = 16'd0;
    else if (rep_q)            gap_d = gap_q + 16'd1;
`endif

    // Registered tick must line up with the cycle where the counter sits on its last value.
    tick_d = (state_d == SEND) && (cnt_d == DIV_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= SEL_IDLE;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= 16'd0;
`ifdef UART_FRAME_SEQ_REPEAT_EN
      gap_q   <= 16'd0;
      rep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
`ifdef UART_FRAME_SEQ_REPEAT_EN
      gap_q   <= gap_d;
      rep_q   <= rep_d;
`endif
    end
  end

  assign bus.sel      = sel_q;
  assign bus.busy     = busy_q;
  assign bus.bit_tick = tick_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_uart_frame_seq.sv
// Directed bench for uart_frame_seq (DIV=4): scoreboard of expected sel/tick per busy cycle plus a mux model.
module tb_uart_frame_seq;
  localparam int DIV = 4;
  localparam int NB  = 40;

  typedef struct packed {
    logic [5:0] sel;
    logic       tick;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [39:0] rx_bits;
  logic [7:0]  msg [4];

  uart_frame_seq_if bus ();

  uart_frame_seq #(.CLK_HZ(50000000), .BAUD(9600), .DIV(DIV), .NBITS(NB),
                   .IDLE_SEL(63), .GAP_BITS(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fixed-message multiplexer: 4 frames of start, 8 data LSB-first, stop; idle level for out-of-range sel.
  function automatic logic mux_txd(input logic [5:0] s);
    int f;
    int b;
    if (s >= 6'(NB)) return 1'b1;
    f = int'(s) / 10;
    b = int'(s) % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return msg[f][b-1];
  endfunction

  task automatic push_msg();
    exp_t e;
    for (int i = 0; i < NB; i++)
      for (int c = 0; c < DIV; c++) begin
        e.sel  = 6'(i);
        e.tick = (c == DIV - 1);
        sb.push_back(e);
      end
  endtask

  task automatic run_msg(input int pulse_sel, input logic hold);
    exp_t e;
    int   ticks;
    bit   pulsed;
    ticks  = 0;
    pulsed = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      e = sb.pop_front();
      check("busy_in_msg", 32'(bus.busy), 32'd1);
      check("sel_walk", 32'(bus.sel), 32'(e.sel));
      check("bit_tick", 32'(bus.bit_tick), 32'(e.tick));
      check("done_in_msg", 32'(bus.done), 32'd0);
      if (bus.bit_tick === 1'b1) begin
        if (ticks < NB) rx_bits[ticks] = mux_txd(bus.sel);
        ticks++;
      end
      bus.start = hold;
      if (!pulsed && int'(bus.sel) == pulse_sel) begin
        bus.start = 1'b1;
        pulsed    = 1;
      end
    end
    check("tick_count", 32'(ticks), 32'(NB));
  endtask

  task automatic end_check();
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("busy_fall", 32'(bus.busy), 32'd0);
    check("sel_park", 32'(bus.sel), 32'd63);
    check("tick_idle", 32'(bus.bit_tick), 32'd0);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_sel", 32'(bus.sel), 32'd63);
      check("idle_done", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] byte_v;
    bit         found;
    checks = 0;
    errors = 0;
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63; msg[3] = 8'h64;
    rst = 1'b1;
    bus.start = 1'b0;

    // Reset values and quiet idle
    @(negedge clk);
    @(negedge clk);
    check("rst_sel", 32'(bus.sel), 32'd63);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_tick", 32'(bus.bit_tick), 32'd0);
    rst = 1'b0;
    idle_check(100);

    // Single message with an ignored start at sel=17
    bus.start = 1'b1;
    push_msg();
    run_msg(17, 1'b0);
    end_check();
    for (int f = 0; f < 4; f++) begin
      check("frame_start", 32'(rx_bits[f*10]), 32'd0);
      check("frame_stop", 32'(rx_bits[f*10+9]), 32'd1);
      byte_v = rx_bits[f*10+1 +: 8];
      check("frame_byte", 32'(byte_v), 32'(8'h61 + f));
    end

`ifdef UART_FRAME_SEQ_REPEAT_EN
    // Automatic repeat: 40 idle cycles (done cycle included) then a new message
    idle_check(39);
    push_msg();
    run_msg(99, 1'b0);
    end_check();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle_check(5);
`else
    idle_check(300);
`endif

    // Back-to-back with start held high
    bus.start = 1'b1;
    push_msg();
    run_msg(99, 1'b1);
    end_check();
    push_msg();
    run_msg(99, 1'b0);
    end_check();
    idle_check(5);

    // Mid-message reset at sel=25
    bus.start = 1'b1;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.sel === 6'd25) found = 1;
    end
    check("reach_sel25", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_sel", 32'(bus.sel), 32'd63);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_tick", 32'(bus.bit_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle_check(250);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
